// File: rtl/div_pkg.sv
// Shared constants and FSM state type for the signed non-restoring divider.
package div_pkg;
  localparam int DIV_WIDTH        = 32;
  localparam int DIV_ITERS        = 32;
  localparam int DIV_DONE_LATENCY = 34;
  localparam int DIV_CNT_W        = 6;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } div_state_e;
endpackage

// File: rtl/div_step.sv
// One combinational non-restoring iteration: shift in the next dividend bit,
// then subtract or add the divisor depending on the partial-remainder sign.
module div_step #(
  parameter int PR_W = 34
) (
  input  logic [PR_W-1:0] rem_i,
  input  logic            bit_i,
  input  logic [PR_W-1:0] dvsr_i,
  output logic [PR_W-1:0] rem_o,
  output logic            qbit_o
);
  logic [PR_W-1:0] shifted;

  assign shifted = {rem_i[PR_W-2:0], bit_i};
  assign rem_o   = rem_i[PR_W-1] ? shifted + dvsr_i : shifted - dvsr_i;
  assign qbit_o  = ~rem_o[PR_W-1];
endmodule

// File: rtl/div_cntrl.sv
// Signed 32-bit iterative divider, 34-cycle latency from start to result strobe.
// DIV_REMAINDER_EN enables the remainder output; otherwise remainder is tied to 0.
module div_cntrl
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             data_res_rdy,
  output logic             data_exception,
  output logic             busy
);
  // Partial remainder needs two guard bits: |divisor| can be 2^31.
  localparam int PR_W = WIDTH + 2;
  localparam logic [DIV_CNT_W-1:0] CNT_CORR = DIV_CNT_W'(DIV_ITERS);
  localparam logic [DIV_CNT_W-1:0] CNT_FIX  = DIV_CNT_W'(DIV_DONE_LATENCY - 1);

  div_state_e           state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [PR_W-1:0]      pr_q, pr_d, step_pr;
  logic [WIDTH-1:0]     qt_q, qt_d, dvsr_q, dvsr_d, quot_q, quot_d;
  logic                 qneg_q, qneg_d, dz_q, dz_d, exc_q, exc_d;
  logic                 step_qbit;
`ifdef DIV_REMAINDER_EN
  logic                 rneg_q, rneg_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
`endif

  div_step #(.PR_W(PR_W)) u_step (
    .rem_i  (pr_q),
    .bit_i  (qt_q[WIDTH-1]),
    .dvsr_i ({2'b00, dvsr_q}),
    .rem_o  (step_pr),
    .qbit_o (step_qbit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pr_d    = pr_q;
    qt_d    = qt_q;
    dvsr_d  = dvsr_q;
    quot_d  = quot_q;
    qneg_d  = qneg_q;
    dz_d    = dz_q;
    exc_d   = exc_q;
`ifdef DIV_REMAINDER_EN
    rneg_d  = rneg_q;
    rem_d   = rem_q;
`endif
    // A start in any state (re)captures operands; RUN/DONE work is abandoned.
    if (ctrl_div) begin
      state_d = RUN;
      cnt_d   = '0;
      pr_d    = '0;
      qt_d    = dividend[WIDTH-1] ? -dividend : dividend;
      dvsr_d  = divisor[WIDTH-1] ? -divisor : divisor;
      qneg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      dz_d    = (divisor == '0);
`ifdef DIV_REMAINDER_EN
      rneg_d  = dividend[WIDTH-1];
`endif
    end else begin
      unique case (state_q)
        RUN: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q < CNT_CORR) begin
            pr_d = step_pr;
            qt_d = {qt_q[WIDTH-2:0], step_qbit};
          end else if (cnt_q == CNT_FIX) begin
            state_d = DONE;
            quot_d  = dz_q ? '0 : (qneg_q ? -qt_q : qt_q);
            exc_d   = dz_q;
`ifdef DIV_REMAINDER_EN
            rem_d   = dz_q ? '0 : (rneg_q ? -pr_q[WIDTH-1:0] : pr_q[WIDTH-1:0]);
`endif
          end else begin
`ifdef DIV_REMAINDER_EN
            if (pr_q[PR_W-1]) pr_d = pr_q + {2'b00, dvsr_q};
`endif
          end
        end
        DONE:    state_d = IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pr_q    <= '0;
      qt_q    <= '0;
      dvsr_q  <= '0;
      quot_q  <= '0;
      qneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      exc_q   <= 1'b0;
`ifdef DIV_REMAINDER_EN
      rneg_q  <= 1'b0;
      rem_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pr_q    <= pr_d;
      qt_q    <= qt_d;
      dvsr_q  <= dvsr_d;
      quot_q  <= quot_d;
      qneg_q  <= qneg_d;
      dz_q    <= dz_d;
      exc_q   <= exc_d;
`ifdef DIV_REMAINDER_EN
      rneg_q  <= rneg_d;
      rem_q   <= rem_d;
`endif
    end
  end

  assign quotient       = quot_q;
  assign data_res_rdy   = (state_q == DONE);
  assign data_exception = data_res_rdy & exc_q;
  assign busy           = (state_q != IDLE);
`ifdef DIV_REMAINDER_EN
  assign remainder      = rem_q;
`else
  assign remainder      = '0;
`endif
endmodule

// File: tb/tb_div_cntrl.sv
// Randomized self-checking bench for div_cntrl against a plain-arithmetic model.
module tb_div_cntrl;
  logic        clk, reset, ctrl_div;
  logic [31:0] dividend, divisor, quotient, remainder;
  logic        data_res_rdy, data_exception, busy;
  int          checks, errors;

  div_cntrl dut (
    .clk(clk), .reset(reset), .ctrl_div(ctrl_div),
    .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder),
    .data_res_rdy(data_res_rdy), .data_exception(data_exception), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic e);
    longint la, lb, lq, lr;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    if (lb == 0) begin
      q = '0; r = '0; e = 1'b1;
    end else begin
      lq = la / lb;
      lr = la % lb;
      q = lq[31:0];
`ifdef DIV_REMAINDER_EN
      r = lr[31:0];
`else
      r = '0;
`endif
      e = 1'b0;
    end
  endfunction

  function automatic logic [31:0] rnd_operand();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0: v = $urandom;
      1: begin
        v = 32'($urandom_range(0, 300));
        if ($urandom_range(0, 1) == 1) v = -v;
      end
      2: case ($urandom_range(0, 4))
        0: v = 32'h0000_0000;
        1: v = 32'h0000_0001;
        2: v = 32'hFFFF_FFFF;
        3: v = 32'h8000_0000;
        default: v = 32'h7FFF_FFFF;
      endcase
      default: v = $urandom >> $urandom_range(0, 31);
    endcase
    return v;
  endfunction

  task automatic test_reset();
    reset = 1'b1; ctrl_div = 1'b1; dividend = 32'd100; divisor = 32'd7;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (data_res_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b exp 0", data_res_rdy); end
    checks++; if (data_exception !== 1'b0) begin errors++; $display("FAIL reset_exc got %b exp 0", data_exception); end
    checks++; if (quotient !== 32'd0) begin errors++; $display("FAIL reset_quot got %h exp 0", quotient); end
    checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL reset_rem got %h exp 0", remainder); end
    reset = 1'b0; ctrl_div = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_division(input int n_rand);
    logic [31:0] ta[6] = '{32'd100, -32'd100, 32'd100, -32'd100, 32'd55, 32'h8000_0000};
    logic [31:0] tb[6] = '{32'd7,   32'd7,    -32'd7,  -32'd7,   32'd0,  32'hFFFF_FFFF};
    logic [31:0] a, b, eq, er;
    logic        ee;
    for (int i = 0; i < 6 + n_rand; i++) begin
      if (i < 6) begin a = ta[i]; b = tb[i]; end
      else begin a = rnd_operand(); b = rnd_operand(); end
      ref_div(a, b, eq, er, ee);
      ctrl_div = 1'b1; dividend = a; divisor = b;
      @(posedge clk); #1;
      ctrl_div = 1'b0; dividend = $urandom; divisor = $urandom;
      for (int k = 1; k <= 40; k++) begin
        @(posedge clk); #1;
        checks++;
        if (data_res_rdy !== 1'(k == 34)) begin
          errors++; $display("FAIL div_rdy op=%0d k=%0d got %b exp %b", i, k, data_res_rdy, k == 34);
        end
        checks++;
        if (busy !== 1'(k <= 34)) begin
          errors++; $display("FAIL div_busy op=%0d k=%0d got %b exp %b", i, k, busy, k <= 34);
        end
        if (k != 34) begin
          checks++;
          if (data_exception !== 1'b0) begin
            errors++; $display("FAIL div_exc_unqual op=%0d k=%0d got %b exp 0", i, k, data_exception);
          end
        end else begin
          checks++;
          if (data_exception !== ee) begin
            errors++; $display("FAIL div_exc %h/%h got %b exp %b", a, b, data_exception, ee);
          end
        end
        if (k >= 34) begin
          checks++;
          if (quotient !== eq) begin
            errors++; $display("FAIL div_quot %h/%h k=%0d got %h exp %h", a, b, k, quotient, eq);
          end
          checks++;
          if (remainder !== er) begin
            errors++; $display("FAIL div_rem %h/%h k=%0d got %h exp %h", a, b, k, remainder, er);
          end
        end
      end
    end
  endtask

  task automatic test_abort();
    int n_rdy = 0;
    ctrl_div = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    ctrl_div = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk); #1;
      if (data_res_rdy) n_rdy++;
      checks++;
      if (data_res_rdy !== 1'(k == 44)) begin
        errors++; $display("FAIL abort_rdy k=%0d got %b exp %b", k, data_res_rdy, k == 44);
      end
      if (k == 44) begin
        checks++;
        if (quotient !== 32'd3) begin errors++; $display("FAIL abort_quot got %h exp 3", quotient); end
        checks++;
        if (remainder !== 32'd0) begin errors++; $display("FAIL abort_rem got %h exp 0", remainder); end
      end
      if (k == 9) begin ctrl_div = 1'b1; dividend = 32'd9; divisor = 32'd3; end
      if (k == 10) ctrl_div = 1'b0;
    end
    checks++;
    if (n_rdy != 1) begin errors++; $display("FAIL abort_rdy_count got %0d exp 1", n_rdy); end
  endtask

  task automatic test_reset_mid();
    ctrl_div = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    ctrl_div = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (k == 20) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
        checks++; if (quotient !== 32'd0) begin errors++; $display("FAIL rstmid_quot got %h exp 0", quotient); end
        checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL rstmid_rem got %h exp 0", remainder); end
        checks++; if (data_exception !== 1'b0) begin errors++; $display("FAIL rstmid_exc got %b exp 0", data_exception); end
        reset = 1'b0; ctrl_div = 1'b0;
      end
      checks++;
      if (data_res_rdy !== 1'b0) begin errors++; $display("FAIL rstmid_rdy k=%0d got %b exp 0", k, data_res_rdy); end
      if (k > 20) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle k=%0d got %b exp 0", k, busy); end
      end
      if (k == 19) begin reset = 1'b1; ctrl_div = 1'b1; dividend = 32'd9; divisor = 32'd3; end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a0, b0, a1, b1, q0, r0, q1, r1;
    logic        e0, e1;
    a0 = rnd_operand(); b0 = rnd_operand(); a1 = rnd_operand(); b1 = rnd_operand();
    ref_div(a0, b0, q0, r0, e0);
    ref_div(a1, b1, q1, r1, e1);
    ctrl_div = 1'b1; dividend = a0; divisor = b0;
    @(posedge clk); #1;
    ctrl_div = 1'b0;
    for (int k = 1; k <= 72; k++) begin
      @(posedge clk); #1;
      checks++;
      if (data_res_rdy !== 1'(k == 34 || k == 69)) begin
        errors++; $display("FAIL b2b_rdy k=%0d got %b", k, data_res_rdy);
      end
      if (k == 34 || k == 69) begin
        checks++;
        if (quotient !== (k == 34 ? q0 : q1)) begin
          errors++; $display("FAIL b2b_quot k=%0d got %h exp %h", k, quotient, k == 34 ? q0 : q1);
        end
        checks++;
        if (remainder !== (k == 34 ? r0 : r1)) begin
          errors++; $display("FAIL b2b_rem k=%0d got %h exp %h", k, remainder, k == 34 ? r0 : r1);
        end
        checks++;
        if (data_exception !== (k == 34 ? e0 : e1)) begin
          errors++; $display("FAIL b2b_exc k=%0d got %b exp %b", k, data_exception, k == 34 ? e0 : e1);
        end
      end
      if (k == 34) begin ctrl_div = 1'b1; dividend = a1; divisor = b1; end
      if (k == 35) ctrl_div = 1'b0;
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b0; ctrl_div = 1'b0; dividend = '0; divisor = '0;
    test_reset();
    test_division(40);
    test_abort();
    test_reset_mid();
    for (int i = 0; i < 4; i++) test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
